// File: rtl/oam_dma_engine_if.sv
// rtl/oam_dma_engine_if.sv - byte-wide memory port shared by the FF46 register and the DMA bus master
interface mem_if;
   logic [15:0] addr_select;
   logic [7:0]  write_value;
   logic        write_enable;
   logic [7:0]  read_out;

   modport master (output addr_select, output write_value, output write_enable, input read_out);
   modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA: copies BYTES bytes from {FF46,idx} into FE00+idx through the MMU
module oam_dma_engine #(
   parameter int BYTES   = 160,
   parameter int RD_WAIT = 1
) (
   input  logic   clk,
   input  logic   rst,
   mem_if.slave   mmio_dma_if,
   mem_if.master  dma_req,
   output logic   dma_active,
   output logic   dma_done
);

   localparam int WCW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_RD, S_WAIT, S_WR} state_t;

   state_t         state, nxt_state;
   logic [7:0]     src_hi, nxt_src;
   logic [7:0]     idx, nxt_idx;
   logic [7:0]     data_q, nxt_data;
   logic [WCW-1:0] wait_cnt, nxt_wait;
   logic           nxt_done;

   // The MMU has already decoded FF46; only the strobe matters here.
   logic unused_addr;
   assign unused_addr = ^mmio_dma_if.addr_select;

   assign mmio_dma_if.read_out = src_hi;

   // Folding E0-FF onto C0-DF keeps DMA reads away from OAM and IO.
   function automatic logic [7:0] fold_src(input logic [7:0] hi);
      return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
   endfunction

   always_comb begin
      nxt_state = state;
      nxt_src   = src_hi;
      nxt_idx   = idx;
      nxt_data  = data_q;
      nxt_wait  = wait_cnt;
      nxt_done  = 1'b0;
      if (mmio_dma_if.write_enable) begin
         nxt_src   = mmio_dma_if.write_value;
         nxt_state = S_START;
         nxt_idx   = 8'd0;
      end else begin
         case (state)
            S_IDLE:  nxt_state = S_IDLE;
            S_START: nxt_state = S_RD;
            S_RD: begin
               nxt_wait  = WCW'(RD_WAIT - 1);
               nxt_state = S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == '0) begin
                  nxt_data  = dma_req.read_out;
                  nxt_state = S_WR;
               end else begin
                  nxt_wait = wait_cnt - 1'b1;
               end
            end
            S_WR: begin
               if (idx == 8'(BYTES - 1)) begin
                  nxt_state = S_IDLE;
                  nxt_done  = 1'b1;
               end else begin
                  nxt_idx   = idx + 8'd1;
                  nxt_state = S_RD;
               end
            end
            default: nxt_state = S_IDLE;
         endcase
      end
   end

   // Bus outputs are registered from the next-state decode so they line up with state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= S_IDLE;
         src_hi               <= 8'hFF;
         idx                  <= 8'd0;
         data_q               <= 8'd0;
         wait_cnt             <= '0;
         dma_req.addr_select  <= 16'hFFFF;
         dma_req.write_value  <= 8'd0;
         dma_req.write_enable <= 1'b0;
         dma_active           <= 1'b0;
         dma_done             <= 1'b0;
      end else begin
         state      <= nxt_state;
         src_hi     <= nxt_src;
         idx        <= nxt_idx;
         data_q     <= nxt_data;
         wait_cnt   <= nxt_wait;
         dma_done   <= nxt_done;
         dma_active <= (nxt_state != S_IDLE);
         case (nxt_state)
            S_RD, S_WAIT: begin
               dma_req.addr_select  <= {fold_src(nxt_src), nxt_idx};
               dma_req.write_value  <= 8'd0;
               dma_req.write_enable <= 1'b0;
            end
            S_WR: begin
               dma_req.addr_select  <= 16'hFE00 + {8'd0, nxt_idx};
               dma_req.write_value  <= nxt_data;
               dma_req.write_enable <= 1'b1;
            end
            default: begin
               dma_req.addr_select  <= 16'hFFFF;
               dma_req.write_value  <= 8'd0;
               dma_req.write_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb/tb_oam_dma_engine.sv - directed bench for oam_dma_engine with a small MMU memory model
module tb_oam_dma_engine;
   logic clk;
   logic rst;
   logic dma_active;
   logic dma_done;

   mem_if mmio ();
   mem_if bus ();

   oam_dma_engine #(.BYTES(160), .RD_WAIT(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .mmio_dma_if (mmio.slave),
      .dma_req     (bus.master),
      .dma_active  (dma_active),
      .dma_done    (dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   logic [7:0] oam [0:159];

   assign bus.read_out = ((bus.addr_select >= 16'hA000 && bus.addr_select <= 16'hBFFF) ||
                          (bus.addr_select >= 16'hFEA0 && bus.addr_select <= 16'hFEFF))
                         ? 8'hFF : mem[bus.addr_select];

   int checks;
   int failures;
   int wr_cnt, bad_wr, act_cnt, done_cnt, done_at, hi_acc, cyc;
   logic [15:0] rd_min, rd_max;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      wr_cnt = 0; bad_wr = 0; act_cnt = 0; done_cnt = 0; done_at = -1;
      hi_acc = 0; cyc = 0; rd_min = 16'hFFFF; rd_max = 16'h0000;
   endtask

   // Samples the current cycle's bus activity, then advances to #1 past the next edge.
   task automatic tick();
      if (bus.write_enable) begin
         wr_cnt++;
         if (bus.addr_select >= 16'hFE00 && bus.addr_select <= 16'hFE9F)
            oam[bus.addr_select - 16'hFE00] = bus.write_value;
         else
            bad_wr++;
      end else if (bus.addr_select != 16'hFFFF) begin
         if (bus.addr_select >= 16'hFE00) hi_acc++;
         if (bus.addr_select < rd_min) rd_min = bus.addr_select;
         if (bus.addr_select > rd_max) rd_max = bus.addr_select;
      end
      if (dma_active) act_cnt++;
      if (dma_done) begin
         done_cnt++;
         done_at = cyc;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_ff46(input logic [7:0] v);
      mmio.write_value  = v;
      mmio.write_enable = 1'b1;
      tick();
      mmio.write_enable = 1'b0;
      mmio.write_value  = 8'h00;
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 160; i++) oam[i] = 8'h00;
   endtask

   int errs;
   int bad;

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0;
      mmio.addr_select  = 16'hFF46;
      mmio.write_value  = 8'h00;
      mmio.write_enable = 1'b0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h11;
      for (int i = 0; i < 160; i++) begin
         mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
         mem[16'hC200 + i] = 8'(i) ^ 8'h3C;
         mem[16'hD300 + i] = 8'(i) ^ 8'hA5;
      end
      clear_oam();
      clear_stats();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", 32'(bus.addr_select), 32'hFFFF);
      chk("rst_we", 32'(bus.write_enable), 32'h0);
      chk("rst_wv", 32'(bus.write_value), 32'h0);
      chk("rst_ff46", 32'(mmio.read_out), 32'hFF);
      chk("rst_active", 32'(dma_active), 32'h0);
      chk("rst_done", 32'(dma_done), 32'h0);
      rst = 1'b1;

      // Idle for 1000 cycles with no stimulus.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         if (bus.addr_select !== 16'hFFFF || bus.write_enable !== 1'b0 ||
             dma_active !== 1'b0 || mmio.read_out !== 8'hFF) bad++;
         tick();
      end
      chk("idle_1000", 32'(bad), 32'h0);

      // Full transfer from C100.
      clear_stats();
      write_ff46(8'hC1);
      chk("c1_start_active", 32'(dma_active), 32'h1);
      chk("c1_start_addr", 32'(bus.addr_select), 32'hFFFF);
      tick();
      chk("c1_first_rd", 32'(bus.addr_select), 32'hC100);
      run(489);
      chk("c1_wr_cnt", 32'(wr_cnt), 32'd160);
      chk("c1_bad_wr", 32'(bad_wr), 32'd0);
      chk("c1_active_cycles", 32'(act_cnt), 32'd481);
      chk("c1_done_cnt", 32'(done_cnt), 32'd1);
      chk("c1_done_at", 32'(done_at), 32'd482);
      errs = 0;
      for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
      chk("c1_oam", 32'(errs), 32'd0);
      chk("c1_ff46", 32'(mmio.read_out), 32'hC1);

      // Echo region F3 folds onto D3.
      clear_stats();
      write_ff46(8'hF3);
      run(490);
      chk("f3_rd_min", 32'(rd_min), 32'hD300);
      chk("f3_rd_max", 32'(rd_max), 32'hD39F);
      chk("f3_hi_acc", 32'(hi_acc), 32'd0);
      chk("f3_oam_5", 32'(oam[5]), 32'(8'h05 ^ 8'hA5));
      chk("f3_oam_159", 32'(oam[159]), 32'(8'd159 ^ 8'hA5));
      chk("f3_ff46", 32'(mmio.read_out), 32'hF3);

      // Restart mid-transfer.
      clear_stats();
      write_ff46(8'hC1);
      run(50);
      write_ff46(8'hC2);
      chk("rs_start_active", 32'(dma_active), 32'h1);
      chk("rs_start_addr", 32'(bus.addr_select), 32'hFFFF);
      tick();
      chk("rs_idx0", 32'(bus.addr_select), 32'hC200);
      run(490);
      errs = 0;
      for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h3C)) errs++;
      chk("rs_oam", 32'(errs), 32'd0);
      chk("rs_done_cnt", 32'(done_cnt), 32'd1);

      // FF46 write coinciding with the final WR.
      clear_stats();
      write_ff46(8'hC1);
      run(480);
      chk("fin_wr_addr", 32'(bus.addr_select), 32'hFE9F);
      chk("fin_wr_we", 32'(bus.write_enable), 32'h1);
      write_ff46(8'hC2);
      chk("fin_restart_active", 32'(dma_active), 32'h1);
      chk("fin_no_done", 32'(dma_done), 32'h0);
      run(490);
      chk("fin_done_cnt", 32'(done_cnt), 32'd1);

      // Unmapped source returns FF.
      clear_oam();
      clear_stats();
      write_ff46(8'hA0);
      run(490);
      errs = 0;
      for (int i = 0; i < 160; i++) if (oam[i] !== 8'hFF) errs++;
      chk("a0_oam_ff", 32'(errs), 32'd0);
      chk("a0_wr_cnt", 32'(wr_cnt), 32'd160);

      // Reset at cycle 200 of a transfer.
      clear_oam();
      clear_stats();
      write_ff46(8'hC1);
      run(199);
      chk("mr_pre_active", 32'(dma_active), 32'h1);
      rst = 1'b0;
      #1;
      chk("mr_addr", 32'(bus.addr_select), 32'hFFFF);
      chk("mr_we", 32'(bus.write_enable), 32'h0);
      chk("mr_active", 32'(dma_active), 32'h0);
      chk("mr_ff46", 32'(mmio.read_out), 32'hFF);
      chk("mr_wr_cnt_before", 32'(wr_cnt), 32'd66);
      @(posedge clk);
      #3;
      rst = 1'b1;
      wr_cnt = 0;
      run(200);
      chk("mr_no_more_wr", 32'(wr_cnt), 32'd0);
      errs = 0;
      for (int i = 0; i < 66; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
      for (int i = 66; i < 160; i++) if (oam[i] !== 8'h00) errs++;
      chk("mr_oam_kept", 32'(errs), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
